ascii_write_scheduler: RTL and testbench

Owns the single write port of the ASCII/VGA text buffer controller and shares it between two requesters. The first is CPU store traffic to the VGA window. The second is an internal register-dump engine that reads every architectural register through the register file debug port and writes each register as 8 hex characters, one text row per register. It replaces the ad-hoc debug print states in the processor top-level FSM with a start/busy/done handshake.

---
 rtl/ascii_write_scheduler.sv | 146 ++++++++++++++
 tb/tb_ascii_write_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_write_scheduler.sv
// Owns the text-buffer write port. CPU stores win arbitration; a register-dump engine
// fills the remaining slots with one 8-hex-digit row per architectural register.
module ascii_write_scheduler #(
  parameter int                   WORD_SIZE = 32,
  parameter int                   ADDR_W    = 13,
  parameter int                   COLS      = 80,
  parameter int                   NUM_REGS  = 32,
  parameter logic [WORD_SIZE-9:0] ATTR      = 24'hFFFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dump_start,
  output logic                 dump_busy,
  output logic                 dump_done,
  output logic [4:0]           dbg_reg_addr,
  input  logic [WORD_SIZE-1:0] dbg_reg_data,
  input  logic                 cpu_req,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic [WORD_SIZE-1:0] cpu_data,
  output logic                 cpu_ack,
  output logic                 ascii_write_en,
  output logic [ADDR_W-1:0]    ascii_write_address,
  output logic [WORD_SIZE-1:0] ascii_input
);
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LATCH, S_EMIT, S_DONE} state_e;

  localparam logic [4:0] LAST_REG = 5'(NUM_REGS - 1);

  state_e               state_q, state_d;
  logic [4:0]           reg_idx_q, reg_idx_d;
  logic [2:0]           nibble_idx_q, nibble_idx_d;
  logic [WORD_SIZE-1:0] capture_q, capture_d;
  logic [4:0]           dbg_addr_q, dbg_addr_d;
  logic                 we_q, we_d;
  logic                 ack_q, ack_d;
  logic [ADDR_W-1:0]    waddr_q, waddr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;

  logic                 cpu_grant;
  logic                 dump_grant;
  logic [2:0]           nibble_sel;
  logic [3:0]           nibble;
  logic [ADDR_W-1:0]    dump_addr;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // The ~ack term caps the CPU at one write every two cycles, so the dump always progresses.
  assign cpu_grant  = cpu_req & ~ack_q;
  assign dump_grant = (state_q == S_EMIT) & ~cpu_grant;

  assign nibble_sel = 3'd7 - nibble_idx_q;
  assign nibble     = capture_q[{nibble_sel, 2'b00} +: 4];
  assign dump_addr  = ADDR_W'(32'(reg_idx_q) * 32'(COLS) + 32'(nibble_idx_q));

  always_comb begin
    // NOTE: every target gets a default before any branch, so no path can infer a latch.
    state_d      = state_q;
    reg_idx_d    = reg_idx_q;
    nibble_idx_d = nibble_idx_q;
    capture_d    = capture_q;
    dbg_addr_d   = dbg_addr_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    ack_d        = cpu_grant;

    if (cpu_grant) begin
      we_d    = 1'b1;
      waddr_d = cpu_addr;
      wdata_d = cpu_data;
    end else if (dump_grant) begin
      we_d    = 1'b1;
      waddr_d = dump_addr;
      wdata_d = {hex_char(nibble), ATTR};
    end

    case (state_q)
      S_IDLE: begin
        if (dump_start) begin
          reg_idx_d = '0;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        dbg_addr_d = reg_idx_q;
        state_d    = S_LATCH;
      end
      S_LATCH: begin
        capture_d    = dbg_reg_data;
        nibble_idx_d = '0;
        state_d      = S_EMIT;
      end
      S_EMIT: begin
        if (dump_grant) begin
          nibble_idx_d = nibble_idx_q + 3'd1;
          if (nibble_idx_q == 3'd7) begin
            if (reg_idx_q == LAST_REG) begin
              state_d = S_DONE;
            end else begin
              reg_idx_d = reg_idx_q + 5'd1;
              state_d   = S_ADDR;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      reg_idx_q    <= '0;
      nibble_idx_q <= '0;
      capture_q    <= '0;
      dbg_addr_q   <= '0;
      we_q         <= 1'b0;
      ack_q        <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      reg_idx_q    <= reg_idx_d;
      nibble_idx_q <= nibble_idx_d;
      capture_q    <= capture_d;
      dbg_addr_q   <= dbg_addr_d;
      we_q         <= we_d;
      ack_q        <= ack_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign dump_busy           = (state_q != S_IDLE);
  assign dump_done           = (state_q == S_DONE);
  assign dbg_reg_addr        = dbg_addr_q;
  assign cpu_ack             = ack_q;
  assign ascii_write_en      = we_q;
  assign ascii_write_address = waddr_q;
  assign ascii_input         = wdata_q;

endmodule

// File: tb/tb_ascii_write_scheduler.sv
// Randomized bench for ascii_write_scheduler: expected dump rows are built from register
// snapshots, CPU stores are tracked in a queue with their due cycle.
module tb_ascii_write_scheduler;
  localparam int NUM_REGS = 32;
  localparam int COLS     = 80;
  localparam int SCR_ROW  = 7;

  typedef struct packed {
    logic [12:0] addr;
    logic [31:0] data;
  } dump_wr_t;

  typedef struct packed {
    logic [12:0] addr;
    logic [31:0] data;
    int          due;
  } cpu_wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        dump_start;
  logic        dump_busy;
  logic        dump_done;
  logic [4:0]  dbg_reg_addr;
  logic [31:0] dbg_reg_data;
  logic        cpu_req;
  logic [12:0] cpu_addr;
  logic [31:0] cpu_data;
  logic        cpu_ack;
  logic        ascii_write_en;
  logic [12:0] ascii_write_address;
  logic [31:0] ascii_input;

  logic [31:0] regs [NUM_REGS];
  assign dbg_reg_data = regs[dbg_reg_addr];

  ascii_write_scheduler dut (
    .clk                 (clk),
    .rst                 (rst),
    .dump_start          (dump_start),
    .dump_busy           (dump_busy),
    .dump_done           (dump_done),
    .dbg_reg_addr        (dbg_reg_addr),
    .dbg_reg_data        (dbg_reg_data),
    .cpu_req             (cpu_req),
    .cpu_addr            (cpu_addr),
    .cpu_data            (cpu_data),
    .cpu_ack             (cpu_ack),
    .ascii_write_en      (ascii_write_en),
    .ascii_write_address (ascii_write_address),
    .ascii_input         (ascii_input)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  dump_wr_t dump_q[$];
  cpu_wr_t  cpu_q[$];

  int cyc = 0;
  int dump_writes = 0;
  int cpu_writes = 0;
  int busy_cycles = 0;
  int done_count = 0;
  int last_dump_cyc = -1;
  int gap_exp = 0;
  bit prev_ack = 1'b0;
  bit prev_done = 1'b0;
  dump_wr_t mon_d;
  cpu_wr_t  mon_c;

  bit          cpu_hold = 1'b0;
  int          shot_req = 0;
  int          shot_done = 0;
  logic [12:0] shot_addr = '0;
  logic [31:0] shot_data = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected dump: one row per register, most significant hex digit at column 0.
  function automatic void build_model();
    string hex = "0123456789ABCDEF";
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int n = 0; n < 8; n++) begin
        dump_wr_t   w;
        logic [3:0] nib;
        nib    = 4'(regs[r] >> (4 * (7 - n)));
        w.addr = 13'(r * COLS + n);
        w.data = {8'(hex.getc(int'(nib))), 24'hFFFFFF};
        dump_q.push_back(w);
      end
    end
  endfunction

  task automatic randomize_regs();
    for (int r = 0; r < NUM_REGS; r++) regs[r] = $urandom;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, dump_busy, 0);
    check({tag, "_done"}, dump_done, 0);
    check({tag, "_dbg_addr"}, dbg_reg_addr, 0);
    check({tag, "_ack"}, cpu_ack, 0);
    check({tag, "_we"}, ascii_write_en, 0);
    check({tag, "_waddr"}, ascii_write_address, 0);
    check({tag, "_wdata"}, ascii_input, 0);
  endtask

  // CPU requester: holds a store until acked, then drops or immediately issues the next one.
  initial begin : cpu_driver
    cpu_req  = 1'b0;
    cpu_addr = '0;
    cpu_data = '0;
    forever begin
      @(negedge clk);
      #1;
      if (cpu_req && cpu_ack) cpu_req = 1'b0;
      if (!cpu_req && rst && (cpu_hold || shot_done != shot_req)) begin
        cpu_wr_t w;
        if (shot_done != shot_req) begin
          cpu_addr = shot_addr;
          cpu_data = shot_data;
          shot_done++;
        end else begin
          cpu_addr = 13'($urandom);
          cpu_data = $urandom;
        end
        cpu_req = 1'b1;
        w.addr  = cpu_addr;
        w.data  = cpu_data;
        w.due   = cyc + (cpu_ack ? 2 : 1);
        cpu_q.push_back(w);
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      last_dump_cyc = -1;
      prev_ack      = 1'b0;
      prev_done     = 1'b0;
    end else begin
      if (ascii_write_en && cpu_ack) begin
        cpu_writes++;
        check("cpu_write_expected", cpu_q.size() != 0, 1);
        if (cpu_q.size() != 0) begin
          mon_c = cpu_q.pop_front();
          check("cpu_addr", ascii_write_address, mon_c.addr);
          check("cpu_data", ascii_input, mon_c.data);
          check("cpu_latency", cyc, mon_c.due);
        end
      end else if (ascii_write_en) begin
        dump_writes++;
        check("dump_write_expected", dump_q.size() != 0, 1);
        if (dump_q.size() != 0) begin
          mon_d = dump_q.pop_front();
          check("dump_addr", ascii_write_address, mon_d.addr);
          check("dump_data", ascii_input, mon_d.data);
          if (gap_exp != 0 && (mon_d.addr % COLS) != 0 && last_dump_cyc >= 0)
            check("dump_gap", cyc - last_dump_cyc, gap_exp);
        end
        last_dump_cyc = cyc;
      end
      if (cpu_ack) begin
        check("ack_with_write", ascii_write_en, 1);
        check("ack_spacing", prev_ack, 0);
      end
      if (dump_busy) busy_cycles++;
      if (dump_done) begin
        done_count++;
        check("done_while_busy", dump_busy, 1);
        check("done_with_last_write", ascii_write_en & ~cpu_ack, 1);
        check("done_queue_drained", dump_q.size(), 0);
        check("done_single_cycle", prev_done, 0);
      end
      prev_ack  = cpu_ack;
      prev_done = dump_done;
    end
  end

  task automatic pulse_start();
    #1 dump_start = 1'b1;
    @(posedge clk);
    #1 dump_start = 1'b0;
  endtask

  task automatic run_dump(input bit with_cpu, input bit extra_starts);
    int w0, b0, d0;
    bit scrambled;
    w0 = dump_writes;
    b0 = busy_cycles;
    d0 = done_count;
    scrambled = 1'b0;
    build_model();
    gap_exp  = with_cpu ? 2 : 1;
    cpu_hold = with_cpu;
    repeat (3) @(negedge clk);
    pulse_start();
    for (int i = 0; i < 4000 && done_count == d0; i++) begin
      @(negedge clk);
      // Row SCR_ROW is already latched once its first digit is out; changing it must not show.
      if (!scrambled && dump_writes - w0 > 8 * SCR_ROW) begin
        regs[SCR_ROW] = ~regs[SCR_ROW];
        scrambled = 1'b1;
      end
      if (extra_starts && (i == 40 || i == 200)) pulse_start();
    end
    check("dump_completed", done_count - d0, 1);
    cpu_hold = 1'b0;
    repeat (20) @(negedge clk);
    check("dump_write_count", dump_writes - w0, 8 * NUM_REGS);
    check("dump_done_count", done_count - d0, 1);
    check("dump_queue_empty", dump_q.size(), 0);
    check("cpu_queue_empty", cpu_q.size(), 0);
    if (with_cpu) check("busy_extended", (busy_cycles - b0) > (10 * NUM_REGS + 1), 1);
    else          check("busy_cycles", busy_cycles - b0, 10 * NUM_REGS + 1);
  endtask

  task automatic cpu_one(input logic [12:0] a, input logic [31:0] d);
    int w0;
    w0 = cpu_writes;
    shot_addr = a;
    shot_data = d;
    shot_req++;
    repeat (5) @(negedge clk);
    check("cpu_single_count", cpu_writes - w0, 1);
    check("cpu_single_queue", cpu_q.size(), 0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int w0;
    rst        = 1'b0;
    dump_start = 1'b0;
    randomize_regs();
    repeat (2) @(negedge clk);
    check_outputs_zero("por");
    #1 rst = 1'b1;

    // Known patterns: 9/A digit boundary in r0, DEADBEEF in r5.
    regs[0] = 32'h01239A0F;
    regs[5] = 32'hDEADBEEF;
    run_dump(1'b0, 1'b0);

    cpu_one(13'h1000, 32'h41FFFFFF);
    for (int k = 0; k < 3; k++) cpu_one(13'($urandom), $urandom);

    // Saturating CPU traffic plus ignored restarts while busy.
    randomize_regs();
    run_dump(1'b1, 1'b1);

    randomize_regs();
    run_dump(1'b0, 1'b1);

    // Asynchronous reset in the middle of a dump, then a clean restart from r0.
    randomize_regs();
    build_model();
    gap_exp = 1;
    w0 = dump_writes;
    @(negedge clk);
    pulse_start();
    for (int i = 0; i < 400 && dump_writes - w0 < 20; i++) @(negedge clk);
    check("reached_emit", (dump_writes - w0) >= 20, 1);
    #2 rst = 1'b0;
    #1 check_outputs_zero("rst_mid");
    repeat (3) @(negedge clk);
    check_outputs_zero("rst_hold");
    dump_q.delete();
    #1 rst = 1'b1;
    randomize_regs();
    run_dump(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
